// File: rtl/acia_brgen_ce.sv
// Baud-rate generator for the 6551 ACIA: emits single-cycle 16x/1x clock enables
// from the SBR table, a custom divisor, or a synchronised external RXC clock.
module acia_brgen_ce #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       SBR,
  input  logic             RCS,
  input  logic             DIV_SEL,
  input  logic [CNT_W-1:0] DIV_CUSTOM,
  input  logic             RXC_IN,
  output logic             TX_TICK,
  output logic             RX_TICK,
  output logic             BIT_TICK,
  output logic             RXC_OUT
);

  function automatic logic [CNT_W-1:0] sbr_divisor(input logic [3:0] sbr);
    int t;
    case (sbr)
      4'h1:    t = 2304;
      4'h2:    t = 1536;
      4'h3:    t = 1048;
      4'h4:    t = 856;
      4'h5:    t = 768;
      4'h6:    t = 384;
      4'h7:    t = 192;
      4'h8:    t = 96;
      4'h9:    t = 64;
      4'hA:    t = 48;
      4'hB:    t = 32;
      4'hC:    t = 24;
      4'hD:    t = 16;
      4'hE:    t = 12;
      4'hF:    t = 6;
      default: t = 0;
    endcase
    return CNT_W'(t * PRESCALE);
  endfunction

  logic             ext_mode;
  logic [CNT_W-1:0] div_calc;
  logic             div_change;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] d_eff_q, d_eff_d;
  logic [3:0]       phase_q, phase_d;
  logic             sync1_q, sync2_q, edge_q;
  logic             tx_tick_q, rx_tick_q, bit_tick_q, rxc_out_q;

  logic             itick;
  logic             etick;
  logic             tx_now;
  logic             rx_now;
  logic             bit_now;
  logic             rxc_now;

  // External mode maps to a divisor of 0 so entering or leaving it always restarts the counter.
  always_comb begin
    ext_mode = 1'b0;
    div_calc = '0;
    if (DIV_SEL) begin
      div_calc = (DIV_CUSTOM < CNT_W'(2)) ? CNT_W'(1) : DIV_CUSTOM;
    end else if (SBR == 4'h0) begin
      ext_mode = 1'b1;
    end else begin
      div_calc = sbr_divisor(SBR);
    end
    div_change = (div_calc != d_eff_q);
  end

  always_comb begin
    d_eff_d = d_eff_q;
    cnt_d   = cnt_q;
    itick   = 1'b0;
    if (div_change) begin
      d_eff_d = div_calc;
      cnt_d   = (div_calc == '0) ? '0 : div_calc - CNT_W'(1);
    end else if (d_eff_q != '0) begin
      if (cnt_q == '0) begin
        cnt_d = d_eff_q - CNT_W'(1);
        itick = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // A divisor change also restarts the 1x phase so BIT_TICK realigns to the new rate.
  always_comb begin
    etick   = sync2_q & ~edge_q;
    tx_now  = ext_mode ? etick : itick;
    rx_now  = RCS ? tx_now : etick;
    bit_now = tx_now && (phase_q == 4'hF) && !div_change;
    rxc_now = (cnt_q < (d_eff_q >> 1));
    phase_d = phase_q;
    if (div_change) begin
      phase_d = 4'h0;
    end else if (tx_now) begin
      phase_d = phase_q + 4'h1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      d_eff_q    <= '0;
      phase_q    <= 4'h0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      tx_tick_q  <= 1'b0;
      rx_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      rxc_out_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      d_eff_q    <= d_eff_d;
      phase_q    <= phase_d;
      sync1_q    <= RXC_IN;
      sync2_q    <= sync1_q;
      edge_q     <= sync2_q;
      tx_tick_q  <= tx_now;
      rx_tick_q  <= rx_now;
      bit_tick_q <= bit_now;
      rxc_out_q  <= rxc_now;
    end
  end

  assign TX_TICK  = tx_tick_q;
  assign RX_TICK  = rx_tick_q;
  assign BIT_TICK = bit_tick_q;
  assign RXC_OUT  = rxc_out_q;

endmodule
